// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the ALU command driver.
package alu_pkg;

    localparam logic [1:0] OP_SUB  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_ONES = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    localparam int FLAG_ERR = 0;
    localparam int FLAG_NEG = 1;
    localparam int FLAG_POS = 2;
    localparam int FLAG_OVF = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } drv_state_e;

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Request, ALU-drive and response signals of alu_cmd_driver, named from the driver's side.
interface alu_cmd_driver_if #(
    parameter int WIDTH = 4
);
    logic             i_req_valid;
    logic             o_req_ready;
    logic [WIDTH-1:0] i_req_arg0;
    logic [WIDTH-1:0] i_req_arg1;
    logic [1:0]       i_req_oper;
    logic [WIDTH-1:0] o_arg0;
    logic [WIDTH-1:0] o_arg1;
    logic [1:0]       o_oper;
    logic [WIDTH-1:0] i_alu_result;
    logic [3:0]       i_alu_flag;
    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [WIDTH-1:0] o_rsp_result;
    logic [3:0]       o_rsp_flag;

    modport master (
        output i_req_valid, i_req_arg0, i_req_arg1, i_req_oper,
        output i_alu_result, i_alu_flag, i_rsp_ready,
        input  o_req_ready, o_arg0, o_arg1, o_oper,
        input  o_rsp_valid, o_rsp_result, o_rsp_flag
    );

    modport slave (
        input  i_req_valid, i_req_arg0, i_req_arg1, i_req_oper,
        input  i_alu_result, i_alu_flag, i_rsp_ready,
        output o_req_ready, o_arg0, o_arg1, o_oper,
        output o_rsp_valid, o_rsp_result, o_rsp_flag
    );
endinterface

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO holding {result, flags}; head reads as zero when empty.
module alu_rsp_fifo #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 2,
    localparam int DW    = WIDTH + 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_count = count_q;
    assign pop_ok  = i_pop && !o_empty;
    assign push_ok = i_push && (!o_full || pop_ok);
    assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_data;
    end
endmodule

// File: rtl/alu_cmd_driver.sv
// Registers ALU requests, captures the ALU result one cycle later and queues responses.
// Optional ALU_DRV_STATS_EN adds saturating error/overflow capture counters.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    alu_cmd_driver_if.slave  bus
`ifdef ALU_DRV_STATS_EN
    ,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_ovf_cnt
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
            $error("alu_cmd_driver: DEPTH must be a power of two >= 2 and CNT_W >= 1");
        end
    endgenerate

    drv_state_e       state_q;
    logic [WIDTH-1:0] arg0_q;
    logic [WIDTH-1:0] arg1_q;
    logic [1:0]       oper_q;
    logic             accept;
    logic             capture;
    logic             fifo_push;
    logic             fifo_pop;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic [WIDTH+3:0] fifo_head;

    assign bus.o_req_ready  = (state_q == ST_IDLE) && (fifo_count < CW'(DEPTH)) && i_rstn;
    assign accept           = bus.i_req_valid && bus.o_req_ready;
    assign capture          = (state_q == ST_DRIVE);
    assign fifo_pop         = !fifo_empty && bus.i_rsp_ready;
    assign fifo_push        = capture && (!fifo_full || fifo_pop);
    assign bus.o_arg0       = arg0_q;
    assign bus.o_arg1       = arg1_q;
    assign bus.o_oper       = oper_q;
    assign bus.o_rsp_valid  = !fifo_empty;
    assign bus.o_rsp_result = fifo_head[WIDTH+3:4];
    assign bus.o_rsp_flag   = fifo_head[3:0];

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            arg0_q  <= '0;
            arg1_q  <= '0;
            oper_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        arg0_q  <= bus.i_req_arg0;
                        arg1_q  <= bus.i_req_arg1;
                        oper_q  <= bus.i_req_oper;
                        state_q <= ST_DRIVE;
                    end
                end
                ST_DRIVE: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    alu_rsp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (fifo_push),
        .i_pop   (fifo_pop),
        .i_data  ({bus.i_alu_result, bus.i_alu_flag}),
        .o_data  (fifo_head),
        .o_count (fifo_count),
        .o_empty (fifo_empty),
        .o_full  (fifo_full)
    );

`ifdef ALU_DRV_STATS_EN
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] ovf_cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            err_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else if (capture) begin
            if (bus.i_alu_flag[FLAG_ERR] && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            if (bus.i_alu_flag[FLAG_OVF] && ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 1'b1;
        end
    end

    assign o_err_cnt = err_cnt_q;
    assign o_ovf_cnt = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Randomized + directed bench for alu_cmd_driver against a latency/queue reference model.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    typedef struct {
        logic [3:0] res;
        logic [3:0] flg;
        int         avail;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    alu_cmd_driver_if #(.WIDTH(WIDTH)) bus ();

`ifdef ALU_DRV_STATS_EN
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] ovf_cnt;
`endif

    alu_cmd_driver #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
`ifdef ALU_DRV_STATS_EN
        ,
        .o_err_cnt (err_cnt),
        .o_ovf_cnt (ovf_cnt)
`endif
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];
    int   edges = 0;
    bit   armed = 0;
    bit   last_acc = 0;
    logic [3:0] last_a0 = '0, last_a1 = '0;
    logic [1:0] last_op = '0;
    int   err_m = 0, ovf_m = 0;
    bit   force_en = 0;
    logic [3:0] force_flag = '0;
    logic [7:0] alu_out;

    function automatic logic [7:0] alu_eval(logic [3:0] a, logic [3:0] b, logic [1:0] op);
        logic [3:0] r;
        logic [3:0] f;
        int d;
        f = '0;
        r = '0;
        case (op)
            OP_SUB: begin
                r = a - b;
                d = int'($signed(a)) - int'($signed(b));
                f[FLAG_OVF] = (d > 7) || (d < -8);
            end
            OP_NAND: r = ~(a & b);
            OP_ONES: begin
                r = 4'hF >> a[1:0];
                f[FLAG_ERR] = (a == 4'h0);
            end
            default: begin
                r = 4'h1 << a[1:0];
                f[FLAG_ERR] = (a[3:2] != 2'b00);
            end
        endcase
        f[FLAG_NEG] = r[3];
        f[FLAG_POS] = !r[3] && (r != 4'h0);
        return {r, f};
    endfunction

    always_comb begin
        alu_out = alu_eval(bus.o_arg0, bus.o_arg1, bus.o_oper);
        if (force_en) alu_out[3:0] = force_flag;
        bus.i_alu_result = alu_out[7:4];
        bus.i_alu_flag   = alu_out[3:0];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Compare outputs before the edge, then update the model with what the edge will do.
    task automatic tick();
        int   vis;
        bit   in_drive;
        bit   exp_ready;
        bit   acc;
        exp_t e;
        logic [7:0] ev;
        @(negedge clk);
        vis = 0;
        in_drive = 0;
        foreach (q[k]) begin
            if (q[k].avail <= edges) vis++;
            else if (q[k].avail == edges + 1) in_drive = 1;
        end
        exp_ready = rstn && !in_drive && (vis < DEPTH);
        if (armed) begin
            check("req_ready",  {31'b0, bus.o_req_ready}, {31'b0, exp_ready});
            check("rsp_valid",  {31'b0, bus.o_rsp_valid}, {31'b0, vis > 0});
            check("rsp_result", {28'b0, bus.o_rsp_result}, (vis > 0) ? {28'b0, q[0].res} : 32'h0);
            check("rsp_flag",   {28'b0, bus.o_rsp_flag},   (vis > 0) ? {28'b0, q[0].flg} : 32'h0);
            check("arg0", {28'b0, bus.o_arg0}, {28'b0, last_a0});
            check("arg1", {28'b0, bus.o_arg1}, {28'b0, last_a1});
            check("oper", {30'b0, bus.o_oper}, {30'b0, last_op});
`ifdef ALU_DRV_STATS_EN
            check("err_cnt", {30'b0, err_cnt}, err_m);
            check("ovf_cnt", {30'b0, ovf_cnt}, ovf_m);
`endif
        end
        acc = 0;
        if (!rstn) begin
            q.delete();
            last_a0 = '0;
            last_a1 = '0;
            last_op = '0;
            err_m = 0;
            ovf_m = 0;
        end else begin
            if (in_drive) begin
                if (q[q.size()-1].flg[FLAG_ERR] && err_m < (1 << CNT_W) - 1) err_m++;
                if (q[q.size()-1].flg[FLAG_OVF] && ovf_m < (1 << CNT_W) - 1) ovf_m++;
            end
            if (vis > 0 && bus.i_rsp_ready) void'(q.pop_front());
            if (bus.i_req_valid && exp_ready) begin
                acc = 1;
                ev = alu_eval(bus.i_req_arg0, bus.i_req_arg1, bus.i_req_oper);
                e.res = ev[7:4];
                e.flg = force_en ? force_flag : ev[3:0];
                e.avail = edges + 2;
                q.push_back(e);
                last_a0 = bus.i_req_arg0;
                last_a1 = bus.i_req_arg1;
                last_op = bus.i_req_oper;
            end
        end
        last_acc = acc;
        @(posedge clk);
        edges++;
        if (!rstn) armed = 1;
        #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        input int max, output bit ok);
        bus.i_req_arg0  = a;
        bus.i_req_arg1  = b;
        bus.i_req_oper  = op;
        bus.i_req_valid = 1'b1;
        ok = 0;
        for (int n = 0; n < max && !ok; n++) begin
            tick();
            ok = last_acc;
        end
        bus.i_req_valid = 1'b0;
    endtask

    bit ok;

    initial begin
        rstn = 1'b0;
        bus.i_req_valid = 1'b1;
        bus.i_req_arg0  = 4'hA;
        bus.i_req_arg1  = 4'h6;
        bus.i_req_oper  = OP_NAND;
        bus.i_rsp_ready = 1'b0;
        tick();
        tick();
        check("rst_no_accept", {31'b0, last_acc}, 32'h0);
        bus.i_req_valid = 1'b0;
        rstn = 1'b1;
        tick();

        // Single op: 5 - 3
        send(4'h5, 4'h3, OP_SUB, 4, ok);
        check("single_acc",  {31'b0, ok}, 32'h1);
        check("single_arg0", {28'b0, bus.o_arg0}, 32'h5);
        check("single_oper", {30'b0, bus.o_oper}, 32'h0);
        tick();
        check("single_valid",  {31'b0, bus.o_rsp_valid}, 32'h1);
        check("single_result", {28'b0, bus.o_rsp_result}, 32'h2);
        check("single_flag",   {28'b0, bus.o_rsp_flag}, 32'h4);
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;

        // Backpressure: third request held until one pop
        send(4'h1, 4'h2, OP_SUB, 4, ok);
        check("bp_acc1", {31'b0, ok}, 32'h1);
        send(4'h7, 4'h9, OP_NAND, 4, ok);
        check("bp_acc2", {31'b0, ok}, 32'h1);
        send(4'h2, 4'h0, OP_DEC, 6, ok);
        check("bp_third_held", {31'b0, ok}, 32'h0);
        bus.i_req_valid = 1'b1;
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        ok = 0;
        for (int n = 0; n < 4 && !ok; n++) begin
            tick();
            ok = last_acc;
        end
        bus.i_req_valid = 1'b0;
        check("bp_third_acc", {31'b0, ok}, 32'h1);
        bus.i_rsp_ready = 1'b1;
        repeat (5) tick();

        // Push and pop in the same cycle with one entry queued
        bus.i_rsp_ready = 1'b0;
        send(4'h3, 4'h3, OP_ONES, 4, ok);
        tick();
        send(4'h8, 4'h1, OP_SUB, 4, ok);
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        check("pp_count_valid", {31'b0, bus.o_rsp_valid}, 32'h1);
        bus.i_rsp_ready = 1'b1;
        repeat (3) tick();

        // Reset during DRIVE drops the in-flight op
        send(4'hC, 4'h4, OP_NAND, 4, ok);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        check("rst_drop_valid", {31'b0, bus.o_rsp_valid}, 32'h0);
        send(4'h6, 4'h2, OP_SUB, 4, ok);
        check("post_rst_acc", {31'b0, ok}, 32'h1);
        repeat (3) tick();

`ifdef ALU_DRV_STATS_EN
        force_en = 1;
        force_flag = 4'b1001;
        for (int i = 0; i < 4; i++) send(4'(i), 4'h1, OP_SUB, 4, ok);
        repeat (3) tick();
        check("stats_err_sat", {30'b0, err_cnt}, 32'h3);
        check("stats_ovf_sat", {30'b0, ovf_cnt}, 32'h3);
        force_en = 0;
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            rstn            = ($urandom_range(0, 59) != 0);
            bus.i_req_valid = $urandom_range(0, 1);
            bus.i_req_arg0  = 4'($urandom);
            bus.i_req_arg1  = 4'($urandom);
            bus.i_req_oper  = 2'($urandom);
            bus.i_rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rstn = 1'b1;
        bus.i_req_valid = 1'b0;
        bus.i_rsp_ready = 1'b1;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Command-side driver for the ALU top level. Accepts operation requests over a valid/ready handshake, registers and drives the ALU operand/opcode inputs, captures the combinational ALU result and 4-bit flag word one cycle later, and buffers completed responses in a small FIFO with its own valid/ready handshake. It sits between a host or sequencer and the ALU, and is the only block that drives the ALU inputs.

## Interface
- WIDTH, 4, operand/result width; must match the ALU's WIDTH
- DEPTH, 2, response FIFO entries (power of two, ≥2)
- CNT_W, 8, width of statistics counters (used only when ALU_DRV_STATS_EN is defined)

- i_clk  in  1  clock; all logic on the rising edge
- i_rstn  in  1  reset, synchronous, active-low
- i_req_valid  in  1  request present
- o_req_ready  out  1  request accepted when high together with i_req_valid
- i_req_arg0 / i_req_arg1  in  WIDTH  request operands
- i_req_oper  in  2  opcode
- o_arg0 / o_arg1  out  WIDTH  registered operands to the ALU
- o_oper  out  2  registered opcode to the ALU
- i_alu_result  in  WIDTH  ALU result (combinational from o_arg*/o_oper)
- i_alu_flag  in  4  ALU flags: [0] err, [1] neg, [2] pos, [3] overflow
- o_rsp_valid  out  1  FIFO not empty
- i_rsp_ready  in  1  consumer pops the head when high together with o_rsp_valid
- o_rsp_result  out  WIDTH  head entry result
- o_rsp_flag  out  4  head entry flags
- o_err_cnt / o_ovf_cnt  out  CNT_W  saturating counters (only with ALU_DRV_STATS_EN)

## Operation
- FSM states: IDLE, DRIVE.
- o_req_ready = (state == IDLE) && (fifo count < DEPTH) && i_rstn.
- IDLE: on i_req_valid && o_req_ready, register the request into o_arg0/o_arg1/o_oper and go to DRIVE.
- DRIVE: unconditionally push {i_alu_result, i_alu_flag} into the FIFO and return to IDLE. o_arg*/o_oper hold their values until the next accept.
- No push can overflow: acceptance requires a free slot, and pops in DRIVE only free more space.
- Pop on o_rsp_valid && i_rsp_ready. Push and pop in the same cycle leave count unchanged; order is strictly FIFO.
- o_rsp_result/o_rsp_flag show the head entry; they are 0 while the FIFO is empty.
- Opcode values are passed through unchecked: 00 sub, 01 nand, 10 starting-ones, 11 one-hot decode.

## Timing
- Reset (i_rstn low at an edge): state IDLE, o_arg0/o_arg1/o_oper = 0, FIFO empty, o_rsp_valid = 0, o_rsp_result/o_rsp_flag = 0, counters = 0. o_req_ready is 0 while i_rstn is low.
- Accept at edge E0; ALU inputs valid after E0; capture at E1; o_rsp_valid high after E1. Request-to-response latency is 2 cycles.
- Throughput is one operation per 2 cycles. o_req_ready is low during DRIVE.
- Reset asserted during DRIVE: the in-flight operation is dropped and no response is produced.

## Configuration
- ALU_DRV_STATS_EN defined: o_err_cnt increments on every capture with i_alu_flag[0] = 1, and o_ovf_cnt increments on every capture with i_alu_flag[3] = 1. Both saturate at all-ones and clear on reset.
- Not defined: the counters and both ports are absent. All other behaviour is identical.

## Structure
- Shared package alu_pkg: opcode constants OP_SUB=2'b00, OP_NAND=2'b01, OP_ONES=2'b10, OP_DEC=2'b11; flag index constants FLAG_ERR=0, FLAG_NEG=1, FLAG_POS=2, FLAG_OVF=3; FSM state enum.
- One sub-module, alu_rsp_fifo: a synchronous FIFO of width WIDTH+4 and depth DEPTH, with push/pop, count, empty and full.

## Test plan
- Reset: hold i_rstn low for 2 cycles with i_req_valid = 1 -> all outputs 0 and no accept; first edge with i_rstn high -> o_req_ready = 1.
- Single op: arg0 = 4'h5, arg1 = 4'h3, oper = 00; ALU model returns 4'h2 with flag 4'b0100 -> o_arg0 = 5 and o_oper = 00 after E0; o_rsp_valid = 1 with result 2 and flag 0100 after E1.
- Backpressure (DEPTH=2): i_rsp_ready = 0 and 3 back-to-back requests -> exactly 2 accepted and the third held with o_req_ready = 0; one pop -> the third is accepted and responses pop in request order.
- Simultaneous push and pop at count = 1 -> count stays 1 and the response order is preserved.
- Reset pulse in DRIVE -> state IDLE, FIFO empty, no response for the dropped op; next request completes normally.
- With ALU_DRV_STATS_EN and CNT_W = 2: 4 captures with flag 4'b1001 -> o_err_cnt = o_ovf_cnt = 3 (saturated).
